// File: rtl/instruction_memory.sv
// -----------------------------------------------------------------------------
// instruction_memory
//   Read-only instruction store for the single-cycle CPU datapath. The byte PC
//   selects a 32-bit word, which is split into Opcode, Rd, Rs1, Rs2 and a
//   sign-extended 14-bit Offset. All outputs are registered and appear one
//   clock after PC is presented.
//
// Parameters
//   Ancho     instruction/PC/Offset width (only 32 is supported)
//   NumInst   number of stored instruction words (word 0 .. NumInst-1)
//   INIT_FILE must be left empty: this ROM holds only its built-in program,
//             and naming an image file stops elaboration with an error
//
// Ports
//   clk     in   1      rising-edge clock
//   rst_n   in   1      synchronous reset, active-low; clears all outputs
//   PC      in   Ancho  byte address of the instruction to fetch
//   Opcode  out  3      instr[2:0]
//   Rd      out  5      instr[7:3]
//   Rs1     out  5      instr[12:8]
//   Rs2     out  5      instr[17:13]
//   Offset  out  Ancho  instr[31:18] sign-extended
//   Valid   out  1      PC was word-aligned and inside the program
// -----------------------------------------------------------------------------
module instruction_memory #(
  parameter int    Ancho     = 32,
  parameter int    NumInst   = 7,
  parameter string INIT_FILE = ""
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Ancho-1:0] PC,
  output logic [2:0]       Opcode,
  output logic [4:0]       Rd,
  output logic [4:0]       Rs1,
  output logic [4:0]       Rs2,
  output logic [Ancho-1:0] Offset,
  output logic             Valid
);

  // Catch unsupported configurations at elaboration instead of misbehaving.
  if (Ancho != 32) begin : g_bad_width
    $error("instruction_memory: only Ancho = 32 is supported");
  end
  if (INIT_FILE != "") begin : g_no_file
    $error("instruction_memory: image files are not loaded; leave INIT_FILE empty");
  end

  // Index width is the full PC word index so high PCs never alias into range.
  localparam logic [29:0] NUM_INST_W = 30'(NumInst);

  // Built-in program; words beyond the table read as zero (NOP).
  function automatic logic [31:0] rom_word(input logic [29:0] idx);
    case (idx)
      30'd0:   rom_word = 32'h0010_0208;  // LW   x1, 4(x2)
      30'd1:   rom_word = 32'h0020_0218;  // LW   x3, 8(x2)
      30'd2:   rom_word = 32'h0000_6122;  // ADD  x4, x1, x3
      30'd3:   rom_word = 32'h0000_242B;  // SUB  x5, x4, x1
      30'd4:   rom_word = 32'h0030_A201;  // SW   x5, 12(x2)
      30'd5:   rom_word = 32'hFFFC_0035;  // ADDI x6, x0, -1
      30'd6:   rom_word = 32'hFFE0_4104;  // BEQ  x1, x2, -8
      default: rom_word = 32'h0000_0000;
    endcase
  endfunction

  logic [29:0] idx_s;
  logic        in_range_s;
  logic [31:0] instr_s;

  logic [2:0]  opcode_r;
  logic [4:0]  rd_r;
  logic [4:0]  rs1_r;
  logic [4:0]  rs2_r;
  logic [31:0] offset_r;
  logic        valid_r;

  assign idx_s      = PC[31:2];
  assign in_range_s = (PC[1:0] == 2'b00) && (idx_s < NUM_INST_W);

  // Select the fetched word; anything out of range becomes an all-zero NOP.
  always_comb begin
    instr_s = 32'h0000_0000;
    if (in_range_s) begin
      instr_s = rom_word(idx_s);
    end else begin
      instr_s = 32'h0000_0000;
    end
  end

  // Output register: reset has priority, otherwise split the fetched word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opcode_r <= 3'd0;
      rd_r     <= 5'd0;
      rs1_r    <= 5'd0;
      rs2_r    <= 5'd0;
      offset_r <= 32'h0000_0000;
      valid_r  <= 1'b0;
    end else begin
      opcode_r <= instr_s[2:0];
      rd_r     <= instr_s[7:3];
      rs1_r    <= instr_s[12:8];
      rs2_r    <= instr_s[17:13];
      offset_r <= {{18{instr_s[31]}}, instr_s[31:18]};
      valid_r  <= in_range_s;
    end
  end

  assign Opcode = opcode_r;
  assign Rd     = rd_r;
  assign Rs1    = rs1_r;
  assign Rs2    = rs2_r;
  assign Offset = offset_r;
  assign Valid  = valid_r;

endmodule

// File: tb/tb_instruction_memory.sv
// -----------------------------------------------------------------------------
// tb_instruction_memory
//   Directed vectors for instruction_memory. The driver applies PC/rst_n just
//   after a falling edge and queues the hand-computed fields expected after
//   the following rising edge; the monitor pops and compares 1 ns after every
//   rising edge.
// -----------------------------------------------------------------------------
module tb_instruction_memory;

  typedef struct packed {
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] off;
    logic        v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PC;
  logic [2:0]  Opcode;
  logic [4:0]  Rd, Rs1, Rs2;
  logic [31:0] Offset;
  logic        Valid;

  int applied = 0;
  int miscompares = 0;
  exp_t sb[$];

  instruction_memory #(.Ancho(32), .NumInst(7), .INIT_FILE("")) dut (
    .clk(clk), .rst_n(rst_n), .PC(PC),
    .Opcode(Opcode), .Rd(Rd), .Rs1(Rs1), .Rs2(Rs2),
    .Offset(Offset), .Valid(Valid)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [2:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] off, input logic v);
    exp_t e;
    e.op = op; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.off = off; e.v = v;
    return e;
  endfunction

  // Hand-decoded program words 0..6
  exp_t w[7];
  exp_t zero_e;
  initial begin
    w[0] = mk(3'd0, 5'd1, 5'd2, 5'd0, 32'd4,        1'b1);
    w[1] = mk(3'd0, 5'd3, 5'd2, 5'd0, 32'd8,        1'b1);
    w[2] = mk(3'd2, 5'd4, 5'd1, 5'd3, 32'd0,        1'b1);
    w[3] = mk(3'd3, 5'd5, 5'd4, 5'd1, 32'd0,        1'b1);
    w[4] = mk(3'd1, 5'd0, 5'd2, 5'd5, 32'd12,       1'b1);
    w[5] = mk(3'd5, 5'd6, 5'd0, 5'd0, 32'hFFFFFFFF, 1'b1);
    w[6] = mk(3'd4, 5'd0, 5'd1, 5'd2, 32'hFFFFFFF8, 1'b1);
    zero_e = mk(3'd0, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
  end

  task automatic step(input logic [31:0] pc, input logic rst, input exp_t e);
    @(negedge clk);
    PC    = pc;
    rst_n = rst;
    sb.push_back(e);
  endtask

  // Monitor: compare registered outputs shortly after each rising edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      exp_t got;
      e   = sb.pop_front();
      got = mk(Opcode, Rd, Rs1, Rs2, Offset, Valid);
      applied++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL vec%0d PC=%h: got op=%0d rd=%0d rs1=%0d rs2=%0d off=%h v=%b, want op=%0d rd=%0d rs1=%0d rs2=%0d off=%h v=%b",
                 applied, PC, got.op, got.rd, got.rs1, got.rs2, got.off, got.v,
                 e.op, e.rd, e.rs1, e.rs2, e.off, e.v);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    PC    = 32'd0;
    #1;
    // Reset held two cycles, then release
    step(32'd0, 1'b0, zero_e);
    step(32'd0, 1'b0, zero_e);
    step(32'd0, 1'b1, w[0]);
    // Sweep all in-range words
    for (int i = 0; i < 7; i++) step(32'(i * 4), 1'b1, w[i]);
    // Spot checks
    step(32'd8,  1'b1, w[2]);
    step(32'd16, 1'b1, w[4]);
    // Out of range, no wrap or aliasing
    step(32'd28,         1'b1, zero_e);
    step(32'hFFFFFFFC,   1'b1, zero_e);
    step(32'h00000004 | 32'h80000000, 1'b1, zero_e);
    step(32'd0,          1'b1, w[0]);
    // Misaligned
    step(32'd2,  1'b1, zero_e);
    step(32'd25, 1'b1, zero_e);
    step(32'd4,  1'b1, w[1]);
    // Reset mid-stream, then recover
    step(32'd20, 1'b0, zero_e);
    step(32'd20, 1'b1, w[5]);
    step(32'd24, 1'b1, w[6]);

    // Drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected responses never checked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
